// File: rtl/bit_serial_processor_n_if.sv
// Control/data bundle between the switch/button front end and the bit-serial processor.
interface bit_serial_processor_n_if #(parameter int WIDTH = 8);
    logic             i_load_a;
    logic             i_load_b;
    logic             i_execute;
    logic [WIDTH-1:0] i_din;
    logic [2:0]       i_f;
    logic [1:0]       i_r;
    logic [WIDTH-1:0] o_aval;
    logic [WIDTH-1:0] o_bval;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_load_a, i_load_b, i_execute, i_din, i_f, i_r,
        input  o_aval, o_bval, o_busy, o_done
    );

    modport slave (
        input  i_load_a, i_load_b, i_execute, i_din, i_f, i_r,
        output o_aval, o_bval, o_busy, o_done
    );
endinterface

// File: rtl/bit_serial_processor_n.sv
// Bit-serial two-register logic processor, STEP bits per clock.
// Optional input debouncing compiled in with BSP_DEBOUNCE_EN.
module bsp_debounce #(
    parameter int CYC = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_in,
    output logic o_level
);
    localparam int CW = (CYC < 2) ? 1 : $clog2(CYC + 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // Level flips only after CYC consecutive disagreeing samples.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_in};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(CYC - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
endmodule

module bit_serial_processor_n #(
    parameter int WIDTH           = 8,
    parameter int STEP            = 1,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    bit_serial_processor_n_if.slave   bus
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

    state_t            r_state, w_next;
    logic [WIDTH-1:0]  r_a, r_b, w_nxt_a, w_nxt_b;
    logic [2:0]        r_f;
    logic [1:0]        r_r;
    logic [CW-1:0]     r_cnt;
    logic              w_ld_a, w_ld_b, w_exe, w_last;
    logic [STEP-1:0]   w_lo_a, w_lo_b, w_res, w_sel_a, w_sel_b;

    if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("bit_serial_processor_n: illegal WIDTH/STEP/DEBOUNCE_CYCLES");
    end

`ifdef BSP_DEBOUNCE_EN
    logic [2:0] w_raw, w_lvl;
    assign w_raw = {bus.i_execute, bus.i_load_b, bus.i_load_a};
    for (genvar g = 0; g < 3; g++) begin : g_db
        bsp_debounce #(.CYC(DEBOUNCE_CYCLES)) u_db (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_in   (w_raw[g]),
            .o_level(w_lvl[g])
        );
    end
    assign {w_exe, w_ld_b, w_ld_a} = w_lvl;
`else
    assign w_ld_a = bus.i_load_a;
    assign w_ld_b = bus.i_load_b;
    assign w_exe  = bus.i_execute;
`endif

    assign w_lo_a = r_a[STEP-1:0];
    assign w_lo_b = r_b[STEP-1:0];
    assign w_last = (r_cnt == CW'(N - 1));

    always_comb begin
        w_res = '0;
        case (r_f)
            3'b000:  w_res = w_lo_a & w_lo_b;
            3'b001:  w_res = w_lo_a | w_lo_b;
            3'b010:  w_res = w_lo_a ^ w_lo_b;
            3'b011:  w_res = '1;
            3'b100:  w_res = ~(w_lo_a & w_lo_b);
            3'b101:  w_res = ~(w_lo_a | w_lo_b);
            3'b110:  w_res = ~(w_lo_a ^ w_lo_b);
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_sel_a = w_lo_a;
        w_sel_b = w_lo_b;
        case (r_r)
            2'b01:   w_sel_b = w_res;
            2'b10:   w_sel_a = w_res;
            2'b11:   begin w_sel_a = w_lo_b; w_sel_b = w_lo_a; end
            default: ;
        endcase
    end

    // Full-width step degenerates to a plain parallel replace.
    if (STEP == WIDTH) begin : g_full
        assign w_nxt_a = w_sel_a;
        assign w_nxt_b = w_sel_b;
    end else begin : g_part
        assign w_nxt_a = {w_sel_a, r_a[WIDTH-1:STEP]};
        assign w_nxt_b = {w_sel_b, r_b[WIDTH-1:STEP]};
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!(w_ld_a || w_ld_b) && w_exe) w_next = S_SHIFT;
            S_SHIFT: if (w_last) w_next = S_HOLD;
            S_HOLD:  if (!w_exe) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_f   <= '0;
            r_r   <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ld_a || w_ld_b) begin
                        if (w_ld_a) r_a <= bus.i_din;
                        if (w_ld_b) r_b <= bus.i_din;
                    end else if (w_exe) begin
                        r_f   <= bus.i_f;
                        r_r   <= bus.i_r;
                        r_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a   <= w_nxt_a;
                    r_b   <= w_nxt_b;
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_aval = r_a;
    assign bus.o_bval = r_b;
    assign bus.o_busy = (r_state == S_SHIFT);
    assign bus.o_done = (r_state == S_SHIFT) && w_last;
endmodule

// File: tb/tb_bit_serial_processor_n.sv
// Directed bench: WIDTH=8 at STEP=1 and STEP=2; debounce checks when BSP_DEBOUNCE_EN is set.
module tb_bit_serial_processor_n;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bit_serial_processor_n_if #(.WIDTH(8)) ifc1 ();
    bit_serial_processor_n_if #(.WIDTH(8)) ifc2 ();

    bit_serial_processor_n #(.WIDTH(8), .STEP(1), .DEBOUNCE_CYCLES(3)) dut1 (
        .i_clk(clk), .i_reset(rst), .bus(ifc1.slave));
    bit_serial_processor_n #(.WIDTH(8), .STEP(2), .DEBOUNCE_CYCLES(3)) dut2 (
        .i_clk(clk), .i_reset(rst), .bus(ifc2.slave));

    typedef struct {
        logic [7:0] a, b;
        logic [2:0] f;
        logic [1:0] r;
        int         hold;
        logic [7:0] ea, eb;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load1(input logic [7:0] a, input logic [7:0] b);
        ifc1.i_din = a; ifc1.i_load_a = 1'b1; tick(); ifc1.i_load_a = 1'b0;
        ifc1.i_din = b; ifc1.i_load_b = 1'b1; tick(); ifc1.i_load_b = 1'b0;
    endtask

    // Execute held for 'hold' cycles inside a fixed 40-cycle window.
    task automatic run1(input int hold, output int busy_n, output int done_n);
        busy_n = 0; done_n = 0;
        ifc1.i_execute = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c == hold) ifc1.i_execute = 1'b0;
            tick();
            if (ifc1.o_busy) busy_n++;
            if (ifc1.o_done) done_n++;
        end
        ifc1.i_execute = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        int   bn, dn;

        vecs[0] = '{8'hB5, 8'h3C, 3'b010, 2'b10, 1,  8'h89, 8'h3C};
        vecs[1] = '{8'h89, 8'h3C, 3'b110, 2'b01, 20, 8'h89, 8'h4A};
        vecs[2] = '{8'hF0, 8'hCC, 3'b000, 2'b10, 2,  8'hC0, 8'hCC};
        vecs[3] = '{8'hF0, 8'hCC, 3'b011, 2'b01, 1,  8'hF0, 8'hFF};
        vecs[4] = '{8'hF0, 8'hCC, 3'b101, 2'b10, 3,  8'h03, 8'hCC};
        vecs[5] = '{8'hF0, 8'hCC, 3'b111, 2'b01, 1,  8'hF0, 8'h00};
        vecs[6] = '{8'hF0, 8'hCC, 3'b100, 2'b10, 1,  8'h3F, 8'hCC};
        vecs[7] = '{8'hAA, 8'h55, 3'b001, 2'b00, 1,  8'hAA, 8'h55};

        {ifc1.i_load_a, ifc1.i_load_b, ifc1.i_execute} = 3'b000;
        {ifc2.i_load_a, ifc2.i_load_b, ifc2.i_execute} = 3'b000;
        ifc1.i_din = '0; ifc1.i_f = '0; ifc1.i_r = '0;
        ifc2.i_din = '0; ifc2.i_f = '0; ifc2.i_r = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        chk("rst_a1", 32'(ifc1.o_aval), 32'h0);
        chk("rst_b1", 32'(ifc1.o_bval), 32'h0);
        chk("rst_busy1", 32'(ifc1.o_busy), 32'h0);
        chk("rst_done1", 32'(ifc1.o_done), 32'h0);
        chk("rst_a2", 32'(ifc2.o_aval), 32'h0);
        chk("rst_b2", 32'(ifc2.o_bval), 32'h0);
        chk("rst_busy2", 32'(ifc2.o_busy), 32'h0);
        chk("rst_done2", 32'(ifc2.o_done), 32'h0);

`ifndef BSP_DEBOUNCE_EN
        foreach (vecs[i]) begin
            load1(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_lda", i), 32'(ifc1.o_aval), 32'(vecs[i].a));
            chk($sformatf("v%0d_ldb", i), 32'(ifc1.o_bval), 32'(vecs[i].b));
            ifc1.i_f = vecs[i].f; ifc1.i_r = vecs[i].r;
            run1(vecs[i].hold, bn, dn);
            chk($sformatf("v%0d_a", i), 32'(ifc1.o_aval), 32'(vecs[i].ea));
            chk($sformatf("v%0d_b", i), 32'(ifc1.o_bval), 32'(vecs[i].eb));
            chk($sformatf("v%0d_busy_cycles", i), 32'(bn), 32'd8);
            chk($sformatf("v%0d_done_pulses", i), 32'(dn), 32'd1);
        end

        // Swap with F/R changed mid-operation: latched values must win.
        load1(8'h89, 8'h4A);
        ifc1.i_f = 3'b110; ifc1.i_r = 2'b11;
        ifc1.i_execute = 1'b1; tick(); ifc1.i_execute = 1'b0;
        tick(); tick();
        ifc1.i_f = 3'b000; ifc1.i_r = 2'b00;
        for (int c = 0; c < 12; c++) tick();
        chk("swap_a", 32'(ifc1.o_aval), 32'h4A);
        chk("swap_b", 32'(ifc1.o_bval), 32'h89);

        // Reset on the 3rd SHIFT edge aborts with no Done.
        ifc1.i_execute = 1'b1; tick(); ifc1.i_execute = 1'b0;
        chk("pre_rst_busy", 32'(ifc1.o_busy), 32'h1);
        dn = 0;
        for (int c = 0; c < 2; c++) begin tick(); if (ifc1.o_done) dn++; end
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_a", 32'(ifc1.o_aval), 32'h0);
        chk("abort_b", 32'(ifc1.o_bval), 32'h0);
        chk("abort_busy", 32'(ifc1.o_busy), 32'h0);
        for (int c = 0; c < 10; c++) begin tick(); if (ifc1.o_done) dn++; end
        chk("abort_no_done", 32'(dn), 32'h0);
        load1(8'hB5, 8'h3C);
        ifc1.i_f = 3'b010; ifc1.i_r = 2'b10;
        run1(1, bn, dn);
        chk("post_rst_a", 32'(ifc1.o_aval), 32'h89);
        chk("post_rst_done", 32'(dn), 32'd1);

        // STEP=2 instance, with loads attempted mid-SHIFT.
        ifc2.i_din = 8'h0F; ifc2.i_load_a = 1'b1; tick(); ifc2.i_load_a = 1'b0;
        ifc2.i_din = 8'hA0; ifc2.i_load_b = 1'b1; tick(); ifc2.i_load_b = 1'b0;
        ifc2.i_f = 3'b001; ifc2.i_r = 2'b10;
        ifc2.i_execute = 1'b1; tick(); ifc2.i_execute = 1'b0;
        bn = ifc2.o_busy ? 1 : 0; dn = 0;
        ifc2.i_din = 8'h55; ifc2.i_load_a = 1'b1; ifc2.i_load_b = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ifc2.o_busy) bn++;
            if (ifc2.o_done) dn++;
            if (c == 2) begin ifc2.i_load_a = 1'b0; ifc2.i_load_b = 1'b0; end
        end
        chk("s2_a", 32'(ifc2.o_aval), 32'hAF);
        chk("s2_b", 32'(ifc2.o_bval), 32'hA0);
        chk("s2_busy_cycles", 32'(bn), 32'd4);
        chk("s2_done_pulses", 32'(dn), 32'd1);
`else
        // 2-cycle glitch must be rejected.
        ifc1.i_din = 8'h77;
        ifc1.i_load_a = 1'b1; tick(); tick(); ifc1.i_load_a = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        chk("glitch_a", 32'(ifc1.o_aval), 32'h0);
        // Level input: A must change on exactly the 6th edge after it rises.
        ifc1.i_load_a = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c < 6) chk($sformatf("db_wait_e%0d", c), 32'(ifc1.o_aval), 32'h0);
            else       chk("db_load", 32'(ifc1.o_aval), 32'h77);
        end
        ifc1.i_load_a = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        chk("db_hold_a", 32'(ifc1.o_aval), 32'h77);
        chk("db_b", 32'(ifc1.o_bval), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
